// File: rtl/fbuf_video_pkg.sv
// Shared video constants: coordinate width, FSM encoding and standard mode bundles.
package fbuf_video_pkg;

   localparam int unsigned COORD_W = 13;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_STOPPING = 2'd2;

   typedef struct packed {
      logic [12:0] h_active;
      logic [12:0] h_fp;
      logic [12:0] h_sync;
      logic [12:0] h_bp;
      logic [12:0] v_active;
      logic [12:0] v_fp;
      logic [12:0] v_sync;
      logic [12:0] v_bp;
      logic        h_sync_active_low;
      logic        v_sync_active_low;
   } video_mode_t;

   localparam video_mode_t MODE_640X480 = '{13'd640, 13'd16, 13'd96, 13'd48,
                                            13'd480, 13'd10, 13'd2, 13'd33, 1'b1, 1'b1};
   localparam video_mode_t MODE_800X600 = '{13'd800, 13'd40, 13'd128, 13'd88,
                                            13'd600, 13'd1, 13'd4, 13'd23, 1'b0, 1'b0};
   localparam video_mode_t MODE_1280X720 = '{13'd1280, 13'd110, 13'd40, 13'd220,
                                             13'd720, 13'd5, 13'd5, 13'd20, 1'b0, 1'b0};
   localparam video_mode_t MODE_1920X1080 = '{13'd1920, 13'd88, 13'd44, 13'd148,
                                              13'd1080, 13'd4, 13'd5, 13'd36, 1'b0, 1'b0};
   localparam video_mode_t MODE_TEST_8X4 = '{13'd8, 13'd1, 13'd2, 13'd1,
                                             13'd4, 13'd1, 13'd2, 13'd1, 1'b1, 1'b1};

endpackage

// File: rtl/fbuf_delay_line.sv
// Fixed-depth register pipeline with synchronous clear; depth 0 is a plain wire.
module fbuf_delay_line #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign o_q = i_d;
      end else begin : g_pipe
         logic [WIDTH-1:0] r_stage [DEPTH];

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            end else begin
               r_stage[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
         end

         assign o_q = r_stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/fbuf_timing_gen.sv
// Parameterised video timing generator with scaled framebuffer addressing and buffer swap.
// Optional FBUF_FRAME_CNT_EN adds a 16-bit frame counter output.
module fbuf_timing_gen
   import fbuf_video_pkg::*;
#(
   parameter int unsigned H_ACTIVE          = 640,
   parameter int unsigned H_FP              = 16,
   parameter int unsigned H_SYNC            = 96,
   parameter int unsigned H_BP              = 48,
   parameter int unsigned V_ACTIVE          = 480,
   parameter int unsigned V_FP              = 10,
   parameter int unsigned V_SYNC            = 2,
   parameter int unsigned V_BP              = 33,
   parameter int unsigned H_SYNC_ACTIVE_LOW = 1,
   parameter int unsigned V_SYNC_ACTIVE_LOW = 1,
   parameter int unsigned SCALE_X           = 1,
   parameter int unsigned SCALE_Y           = 1,
   parameter int unsigned DOUBLE_BUF        = 0,
   parameter int unsigned FBUF_ADDR_WIDTH   = 19,
   parameter int unsigned CONTROL_DELAY     = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_swap_req,
   output logic                       o_swap_ack,
   output logic                       o_display_buf,
   output logic                       o_running,
   output logic                       o_hsync,
   output logic                       o_vsync,
   output logic                       o_vde,
   output logic                       o_eof,
   output logic                       o_sof,
   output logic [COORD_W-1:0]         o_pixel_x,
   output logic [COORD_W-1:0]         o_pixel_y,
   output logic [FBUF_ADDR_WIDTH-1:0] o_pixel_fbuf_address,
   output logic                       o_pixel_fbuf_address_valid
`ifdef FBUF_FRAME_CNT_EN
   ,
   output logic [15:0]                o_frame_count
`endif
);

   localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned LINE_WORDS  = H_ACTIVE / SCALE_X;
   localparam int unsigned FRAME_WORDS = LINE_WORDS * (V_ACTIVE / SCALE_Y);

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] V_SWAP   = COORD_W'(V_ACTIVE - 1);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [2:0]         SX_LAST  = 3'(SCALE_X - 1);
   localparam logic [2:0]         SY_LAST  = 3'(SCALE_Y - 1);
   localparam logic [FBUF_ADDR_WIDTH-1:0] LW_C = FBUF_ADDR_WIDTH'(LINE_WORDS);
   localparam logic [FBUF_ADDR_WIDTH-1:0] FW_C = FBUF_ADDR_WIDTH'(FRAME_WORDS);
   localparam logic HS_POL = (H_SYNC_ACTIVE_LOW != 0);
   localparam logic VS_POL = (V_SYNC_ACTIVE_LOW != 0);
   localparam int unsigned CTL_W = 5 + 2 * COORD_W;

   logic [1:0]         r_state, w_state_next;
   logic [COORD_W-1:0] r_h, r_v;
   logic               w_run, w_h_last, w_v_last, w_frame_end, w_de;

   assign w_run       = (r_state != ST_IDLE);
   assign w_h_last    = (r_h == H_LAST);
   assign w_v_last    = (r_v == V_LAST);
   assign w_frame_end = w_run & w_h_last & w_v_last;
   assign w_de        = w_run & (r_h < H_ACT_C) & (r_v < V_ACT_C);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:     if (i_en) w_state_next = ST_RUN;
         ST_RUN:      if (!i_en) w_state_next = ST_STOPPING;
         ST_STOPPING: begin
            if (i_en)             w_state_next = ST_RUN;
            else if (w_frame_end) w_state_next = ST_IDLE;
         end
         default:     w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_h     <= '0;
         r_v     <= '0;
      end else begin
         r_state <= w_state_next;
         if (!w_run) begin
            r_h <= '0;
            r_v <= '0;
         end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 13'd1;
         end else begin
            r_h <= r_h + 13'd1;
         end
      end
   end

   // Incremental scaled addressing: sx/sy replicate, col/line_base step by words.
   logic [2:0]                 r_sx, r_sy;
   logic [FBUF_ADDR_WIDTH-1:0] r_col, r_line_base, w_addr;
   logic [FBUF_ADDR_WIDTH-1:0] r_addr;
   logic                       r_addr_valid, r_disp;

   always_ff @(posedge i_clk) begin
      if (i_rst || !w_run || w_frame_end) begin
         r_sx        <= '0;
         r_sy        <= '0;
         r_col       <= '0;
         r_line_base <= '0;
      end else if (w_h_last) begin
         r_sx  <= '0;
         r_col <= '0;
         if (r_v < V_ACT_C) begin
            if (r_sy == SY_LAST) begin
               r_sy        <= '0;
               r_line_base <= r_line_base + LW_C;
            end else begin
               r_sy <= r_sy + 3'd1;
            end
         end
      end else if (w_de) begin
         if (r_sx == SX_LAST) begin
            r_sx  <= '0;
            r_col <= r_col + 1'b1;
         end else begin
            r_sx <= r_sx + 3'd1;
         end
      end
   end

   assign w_addr = (r_disp ? FW_C : '0) + r_line_base + r_col;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr       <= '0;
         r_addr_valid <= 1'b0;
      end else begin
         r_addr       <= w_de ? w_addr : '0;
         r_addr_valid <= w_de;
      end
   end

   // Swap lands at the end of the last active line, or at once when idle.
   logic r_pending, r_ack, w_pend, w_take;

   assign w_pend = r_pending | i_swap_req;
   assign w_take = w_pend & (!w_run | (w_h_last & (r_v == V_SWAP)));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pending <= 1'b0;
         r_ack     <= 1'b0;
         r_disp    <= 1'b0;
      end else begin
         r_ack <= w_take;
         if (w_take) begin
            r_pending <= 1'b0;
            if (DOUBLE_BUF != 0) r_disp <= ~r_disp;
         end else begin
            r_pending <= w_pend;
         end
      end
   end

   logic             w_hs, w_vs, w_eof, w_sof;
   logic [CTL_W-1:0] w_ctl, r_ctl1, w_ctl_q;

   assign w_hs  = w_run & (r_h >= HS_START) & (r_h < HS_END);
   assign w_vs  = w_run & (r_v >= VS_START) & (r_v < VS_END);
   assign w_eof = w_run & (r_v >= V_ACT_C);
   assign w_sof = w_run & (r_h == '0) & (r_v == '0);
   assign w_ctl = {w_de, w_hs, w_vs, w_eof, w_sof, (w_de ? r_h : '0), (w_de ? r_v : '0)};

   always_ff @(posedge i_clk) begin
      if (i_rst) r_ctl1 <= '0;
      else       r_ctl1 <= w_ctl;
   end

   fbuf_delay_line #(
      .WIDTH (CTL_W),
      .DEPTH (CONTROL_DELAY)
   ) u_ctl_delay (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (r_ctl1),
      .o_q   (w_ctl_q)
   );

   assign o_vde                      = w_ctl_q[CTL_W-1];
   assign o_hsync                    = w_ctl_q[CTL_W-2] ^ HS_POL;
   assign o_vsync                    = w_ctl_q[CTL_W-3] ^ VS_POL;
   assign o_eof                      = w_ctl_q[CTL_W-4];
   assign o_sof                      = w_ctl_q[CTL_W-5];
   assign o_pixel_x                  = w_ctl_q[2*COORD_W-1:COORD_W];
   assign o_pixel_y                  = w_ctl_q[COORD_W-1:0];
   assign o_pixel_fbuf_address       = r_addr;
   assign o_pixel_fbuf_address_valid = r_addr_valid;
   assign o_swap_ack                 = r_ack;
   assign o_display_buf              = r_disp;
   assign o_running                  = w_run;

`ifdef FBUF_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)      r_frame_cnt <= '0;
      else if (o_sof) r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign o_frame_count = r_frame_cnt;
`endif

endmodule

// File: doc/fbuf_timing_gen.md
Name: fbuf_timing_gen

Overview:
- Successor to the fixed-mode framebuffer scan-out block.
- Generates video timing (hsync, vsync, vde, eof, sof) plus a framebuffer read address for any CEA/VESA-style mode, given directly as parameters.
- Supports independent integer X/Y upscaling without dividers or multipliers, double-buffered framebuffer selection with a vblank-synchronous swap handshake, and run/stop control at frame boundaries.
- Sits between the framebuffer BRAM and the RGB-to-DVI encoder.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_ACTIVE_LOW, 1, 1 = hsync asserted low
- V_SYNC_ACTIVE_LOW, 1, 1 = vsync asserted low
- SCALE_X, 1, horizontal replication factor 1..8; H_ACTIVE must be a multiple of it
- SCALE_Y, 1, vertical replication factor 1..8; V_ACTIVE must be a multiple of it
- DOUBLE_BUF, 0, 1 = two frame buffers stacked in the address space
- FBUF_ADDR_WIDTH, 19, address width; must hold (1+DOUBLE_BUF)*FRAME_WORDS
- CONTROL_DELAY, 2, extra control-path delay matching BRAM read latency

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run request
- swap_req  in  1  one-cycle request to flip the displayed buffer
- swap_ack  out  1  one-cycle pulse when the swap takes effect
- display_buf  out  1  currently scanned buffer index
- running  out  1  timing is active
- hsync  out  1  horizontal sync, polarity per parameter
- vsync  out  1  vertical sync, polarity per parameter
- vde  out  1  video data enable
- eof  out  1  high during vertical blanking
- sof  out  1  one-cycle pulse at pixel (0,0)
- pixel_x  out  13  active x, 0 outside active
- pixel_y  out  13  active y, 0 outside active
- pixel_fbuf_address  out  FBUF_ADDR_WIDTH  BRAM read address
- pixel_fbuf_address_valid  out  1  address is for an active pixel

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - LINE_WORDS = H_ACTIVE/SCALE_X; FRAME_WORDS = LINE_WORDS*V_ACTIVE/SCALE_Y.
- FSM:
  - States: IDLE, RUN, STOPPING.
  - IDLE→RUN when en=1; h_cnt=v_cnt=0 on the first RUN cycle.
  - RUN→STOPPING when en=0.
  - STOPPING→RUN if en returns to 1 before frame end.
  - STOPPING→IDLE after the cycle h=H_TOTAL-1, v=V_TOTAL-1.
  - running=1 in RUN and STOPPING.
- Counters (13-bit):
  - h_cnt wraps at H_TOTAL-1; v_cnt increments on h wrap and wraps at V_TOTAL-1.
  - Both are held at 0 in IDLE.
- Addressing: incremental only; no divide or multiply in RTL.
  - sx counts 0..SCALE_X-1 across active pixels; col increments on sx wrap.
  - sy counts 0..SCALE_Y-1 per active line; line_base += LINE_WORDS on sy wrap at end of line.
  - Address = buf_base + line_base + col, where buf_base = display_buf ? FRAME_WORDS : 0.
  - sx, col, sy and line_base all reset at frame start.
- Latency:
  - pixel_fbuf_address and _valid are registered 1 cycle after the counters.
  - vde, hsync, vsync, eof, sof, pixel_x and pixel_y are registered CONTROL_DELAY+1 cycles after the counters, so they align with BRAM data.
  - Address is 0 when not valid.
- Swap:
  - swap_req sets a pending flag; further requests while pending merge into it.
  - At the cycle h=H_TOTAL-1, v=V_ACTIVE-1, a pending flag toggles display_buf (only if DOUBLE_BUF=1), clears, and swap_ack pulses the next cycle.
  - A swap_req arriving on that exact cycle is taken in that frame.
  - In IDLE, a pending swap is applied immediately: display_buf toggles and swap_ack pulses on the following cycle.
- IDLE outputs: vde, valid and sof = 0; syncs at their inactive level; eof = 0.
- Reset (also mid-frame): next edge forces
  - FSM=IDLE, counters/pending/display_buf=0;
  - all pipeline stages cleared, syncs at their inactive level, swap_ack=0.

Optional Feature:
- FBUF_FRAME_CNT_EN:
  - Defined: adds output frame_count [15:0], incremented on every sof, wrapping at 0xFFFF→0, cleared by rst.
  - Undefined: no port and no logic.

Decomposition:
- Package fbuf_video_pkg holds:
  - mode constant sets (640x480, 800x600, 1280x720, 1920x1080, tiny 8x4 test mode) as parameter bundles;
  - FSM state encoding;
  - the 13-bit coordinate width.
- Sub-module fbuf_delay_line (width, depth) implements the CONTROL_DELAY pipeline for the control and coordinate signals.

Test Plan:
- Test mode for all scenarios: H 8/1/2/1 (H_TOTAL=12), V 4/1/2/1 (V_TOTAL=8), SCALE 2x2, DOUBLE_BUF=1, active-low syncs, CONTROL_DELAY=2.
- Basic timing: en=1 → hsync low exactly on h=9..10 delayed 3 cycles; vde high 8 of every 12 cycles on lines 0..3; sof once per 96 clocks.
- Address sequence: line 0 → 0,0,1,1,2,2,3,3; line 3 → 4,4,5,5,6,6,7,7; pixel (5,3) → address 6.
- Swap: swap_req mid-frame → swap_ack on the cycle after h=11, v=3; next frame pixel (5,3) → address 14; two requests in one frame → single toggle.
- Stop: en=0 at v=2 → frame completes, running=0 after 96th clock, syncs held high, vde=0; en=1 → restarts at (0,0) with sof.
- Reset mid-line at h=5, v=1 → next cycle all outputs at reset values; after release and en, first valid address = 0.
- Frame counter (FBUF_FRAME_CNT_EN): frame_count = 3 after 3 sof pulses.
